// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encodings, BCD constants and prescaler defaults shared by the stopwatch controller.
package stopwatch_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;
   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int TICK_DIV_SYN = 100000000;
   localparam int TICK_DIV_SIM = 4;
   localparam int CNT_W_SYN = 27;
endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: button pulses and at_max in, counter strobes and status out.
interface stopwatch_if;
   import stopwatch_pkg::*;
   logic   start_stop;
   logic   clear;
   logic   lap;
   logic   at_max;
   logic   increase;
   logic   load_def;
   logic   freeze;
   state_e state;
   logic   running;
   modport master (output start_stop, clear, lap, at_max,
                   input increase, load_def, freeze, state, running);
   modport slave (input start_stop, clear, lap, at_max,
                  output increase, load_def, freeze, state, running);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the last count; clr has priority.
module tick_prescaler #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic last;
   assign last = cnt_q == CNT_W'(TICK_DIV - 1);
   assign tick = en && last;
   always_comb begin
      cnt_d = clr ? '0 : en ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause FSM turning button pulses into increase/load_def strobes for a BCD digit chain.
// Define AUTO_STOP_EN to halt in DONE when a tick arrives with the chain at its maximum.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_SYN,
   parameter int CNT_W = CNT_W_SYN
) (
   input logic      clk,
   input logic      rst_n,
   stopwatch_if.slave sw
);
   state_e st_q, st_d;
   logic inc_q, inc_d, ld_q, ld_d, frz_q, frz_d;
   logic tick, stop_hit;
   tick_prescaler #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_presc (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (st_q == ST_RUN && !sw.clear),
      .clr  (sw.clear),
      .tick (tick)
   );
`ifdef AUTO_STOP_EN
   assign stop_hit = tick && sw.at_max;
`else
   assign stop_hit = 1'b0;
`endif
   always_comb begin
      case (st_q)
         ST_RUN:   st_d = sw.start_stop ? ST_PAUSE : stop_hit ? ST_DONE : ST_RUN;
         ST_PAUSE: st_d = sw.start_stop ? ST_RUN : ST_PAUSE;
`ifdef AUTO_STOP_EN
         ST_DONE:  st_d = ST_DONE;
`endif
         default:  st_d = sw.start_stop ? ST_RUN : ST_IDLE;
      endcase
      if (sw.clear) st_d = ST_IDLE;
      // load strobe reuses increase, since digits only accept def_value while increase=1
      inc_d = sw.clear || (tick && !sw.start_stop && !stop_hit);
      ld_d = sw.clear;
      frz_d = sw.clear ? 1'b0 : (sw.lap && (st_q == ST_RUN || st_q == ST_PAUSE)) ? !frz_q : frz_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= ST_IDLE;
         inc_q <= 1'b0;
         ld_q <= 1'b0;
         frz_q <= 1'b0;
      end else begin
         st_q <= st_d;
         inc_q <= inc_d;
         ld_q <= ld_d;
         frz_q <= frz_d;
      end
   end
   assign sw.increase = inc_q;
   assign sw.load_def = ld_q;
   assign sw.freeze = frz_q;
   assign sw.state = st_q;
   assign sw.running = st_q == ST_RUN;
endmodule
